// File: rtl/imm_instr_encoder_if.sv
// Field-record input stream and encoded-word output stream of the immediate encoder.
// The master side is the record producer / word consumer; the encoder is the slave.
interface imm_instr_encoder_if #(
   parameter int INTRSIZE = 32,
   parameter int IMMSIZE  = 32,
   parameter int ADDRSIZE = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [1:0]          in_fmt;
   logic [4:0]          in_rd;
   logic [4:0]          in_rs1;
   logic [4:0]          in_rs2;
   logic [2:0]          in_funct3;
   logic [IMMSIZE-1:0]  in_imm;
   logic                out_valid;
   logic                out_ready;
   logic [INTRSIZE-1:0] out_instr;
   logic [ADDRSIZE-1:0] out_addr;

   modport master (
      output in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
      input  in_ready, out_valid, out_instr, out_addr
   );

   modport slave (
      input  in_valid, in_fmt, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
      output in_ready, out_valid, out_instr, out_addr
   );
endinterface

// File: rtl/imm_instr_encoder.sv
// Packs decoded RV32I fields (I/L/S/B formats) into instruction words with byte
// addresses, one burst of records per start pulse; unencodable immediates are dropped.
//
// state  | meaning
// IDLE   | waiting for the first start after reset
// ACTIVE | accepting records until the burst count is exhausted
// DRAIN  | all records consumed, last word still waiting in the output register
// DONE   | burst complete; a new start begins a fresh burst
module imm_instr_encoder #(
   parameter int INTRSIZE = 32,
   parameter int IMMSIZE  = 32,
   parameter int ADDRSIZE = 32,
   parameter int CNTSIZE  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDRSIZE-1:0] base_addr,
   input  logic [CNTSIZE-1:0]  count,
   imm_instr_encoder_if.slave  bus,
   output logic                busy,
   output logic                done,
   output logic [CNTSIZE-1:0]  err_count
);

   typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN, S_DONE} state_t;

   state_t               state, state_nxt;
   logic [CNTSIZE-1:0]   remaining;
   logic [ADDRSIZE-1:0]  next_addr;
   logic                 out_valid;
   logic [INTRSIZE-1:0]  out_instr;
   logic [ADDRSIZE-1:0]  out_addr;
   logic                 in_ready;
   logic                 start_ok;
   logic                 consume;
   logic                 load;
   logic                 imm_ok;
   logic [6:0]           opcode;
   logic [INTRSIZE-1:0]  enc;
   logic [IMMSIZE-1:0]   imm;

   assign imm       = bus.in_imm;
   assign start_ok  = start && (state == S_IDLE || state == S_DONE);
   assign in_ready  = (state == S_ACTIVE) && (!out_valid || bus.out_ready);
   assign consume   = bus.in_valid && in_ready;
   assign load      = consume && imm_ok;

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_instr = out_instr;
   assign bus.out_addr  = out_addr;
   assign busy          = (state == S_ACTIVE) || (state == S_DRAIN);
   assign done          = (state == S_DONE);

   // Encodable iff the bits above the field's sign bit are pure sign extension.
   always_comb begin
      opcode = 7'b0010011;
      imm_ok = 1'b0;
      enc    = '0;
      case (bus.in_fmt)
         2'd0, 2'd1: begin
            opcode = (bus.in_fmt == 2'd0) ? 7'b0010011 : 7'b0000011;
            imm_ok = (&imm[IMMSIZE-1:11]) || !(|imm[IMMSIZE-1:11]);
            enc    = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, opcode};
         end
         2'd2: begin
            opcode = 7'b0100011;
            imm_ok = (&imm[IMMSIZE-1:11]) || !(|imm[IMMSIZE-1:11]);
            enc    = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0], opcode};
         end
         default: begin
            opcode = 7'b1100011;
            imm_ok = ((&imm[IMMSIZE-1:12]) || !(|imm[IMMSIZE-1:12])) && !imm[0];
            enc    = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                      imm[4:1], imm[11], opcode};
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (start) state_nxt = (count == '0) ? S_DONE : S_ACTIVE;
         end
         S_ACTIVE: begin
            if (consume && remaining == CNTSIZE'(1)) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (!out_valid || bus.out_ready) state_nxt = S_DONE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         remaining <= '0;
         next_addr <= '0;
         err_count <= '0;
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= '0;
      end else begin
         if (start_ok) begin
            remaining <= count;
            next_addr <= base_addr;
            err_count <= '0;
         end else if (consume) begin
            remaining <= remaining - 1'b1;
            if (imm_ok)
               next_addr <= next_addr + ADDRSIZE'(4);
            else if (err_count != '1)
               err_count <= err_count + 1'b1;
         end
         // A fresh load wins over a drain so back-to-back words flow at full rate.
         if (load) begin
            out_valid <= 1'b1;
            out_instr <= enc;
            out_addr  <= next_addr;
         end else if (bus.out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/imm_instr_encoder.md
Name: imm_instr_encoder

Overview:
- Inverse of the immediate decode path: packs decoded fields (format, registers, funct3, 32-bit sign-extended immediate) into 32-bit RV32I instruction words.
- Emits words with byte addresses through a valid/ready stream toward the instruction-memory writer (program loader / test-program builder).
- Runs in bursts: a start pulse loads a base address and word count; the block accepts that many field records, then signals done.
- Records whose immediate cannot be encoded are dropped and counted.

Parameters:
- INTRSIZE, 32, instruction word width.
- IMMSIZE, 32, width of input immediate (sign-extended value).
- ADDRSIZE, 32, output address width.
- CNTSIZE, 16, width of burst count and error counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  burst start pulse; honoured only in IDLE or DONE.
- base_addr  input  ADDRSIZE  address of first word; sampled on start.
- count  input  CNTSIZE  records to accept in this burst; sampled on start.
- in_valid  input  1  field record valid.
- in_ready  output  1  block can accept a record this cycle.
- in_fmt  input  2  format: 0=I (opcode 0010011), 1=L (0000011), 2=S (0100011), 3=B (1100011).
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_funct3  input  3  funct3 field.
- in_imm  input  IMMSIZE  sign-extended immediate value.
- out_valid  output  1  instruction word valid.
- out_ready  input  1  downstream accepts the word.
- out_instr  output  INTRSIZE  encoded instruction.
- out_addr  output  ADDRSIZE  byte address of out_instr.
- busy  output  1  high in ACTIVE or DRAIN.
- done  output  1  high in DONE.
- err_count  output  CNTSIZE  records rejected since last start; saturates at all-ones.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=0, busy=0, done=0, err_count=0, in_ready=0; state=IDLE.
- States and transitions:
  - IDLE: start -> ACTIVE (count=0 -> DONE directly).
  - ACTIVE: leaves when the last record is consumed -> DRAIN.
  - DRAIN: once the output register is empty, or emptied this cycle -> DONE.
  - DONE: holds until start; start -> ACTIVE with a fresh burst.
  - start in ACTIVE or DRAIN is ignored.
- On accepted start: remaining=count, next_addr=base_addr, err_count=0, done deasserted the next cycle.
- in_ready = (state==ACTIVE) && (!out_valid || out_ready).
- Handshake: a record is consumed when in_valid && in_ready. Every consumed record decrements remaining, valid or rejected.
- Encoding (imm = in_imm):
  - I/L: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Range check:
  - I/L/S: imm must lie in -2048..2047, i.e. bits [31:11] all equal.
  - B: imm must lie in -4096..4094, i.e. bits [31:12] all equal, and imm[0]=0.
  - A failing record is consumed, produces no output and leaves next_addr unchanged. err_count increments, saturating at all-ones.
- Output latency: 1 cycle. A valid record loads out_instr and out_addr=next_addr, sets out_valid, and advances next_addr by 4.
- out_instr and out_addr hold stable while out_valid && !out_ready.
- out_valid clears on out_ready unless a new word loads in the same cycle; simultaneous drain and load gives back-to-back throughput of 1 word per cycle.
- next_addr wraps modulo 2^ADDRSIZE.
- rst mid-burst: all state returns to reset values next edge; a pending output word is discarded.

Test Plan:
- start base=0x100, count=1; I record rd=1, rs1=0, f3=0, imm=5 -> out_instr=0x00500093, out_addr=0x100 one cycle after accept; then done=1.
- count=3 back-to-back with out_ready=1:
  - L rd=3, rs1=2, f3=2, imm=-4 -> 0xFFC12183 @base.
  - S rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423 @base+4.
  - B rs1=1, rs2=2, f3=0, imm=-8 -> 0xFE208CE3 @base+8.
  - in_ready stays high throughout.
- Backpressure: out_ready=0 for 5 cycles with a word pending -> in_ready=0; out_instr and out_addr stable; no record lost; resumes when out_ready=1.
- Rejects, count=3:
  - I with imm=2048 -> no output, err_count=1.
  - B with imm=7 -> no output, err_count=2.
  - I with imm=-2048 -> 0x80000013 at base (address not advanced by the rejects).
- rst asserted while out_valid=1 in ACTIVE -> next cycle out_valid=0, state IDLE, err_count=0; start ignored during ACTIVE; start with count=0 -> done=1 with no output.
